// File: rtl/frame_wr_ctrl.sv
// Write-side feeder for ddr_burst: packs pixels into words, buffers them in a show-ahead
// FIFO and issues fixed-length write bursts. Define FRAME_WR_PINGPONG_EN to alternate banks.
module frame_wr_ctrl #(
  parameter int ADDR_WIDTH  = 28,
  parameter int DATA_WIDTH  = 128,
  parameter int PIX_WIDTH   = 16,
  parameter int BURST_LEN   = 64,
  parameter int FIFO_DEPTH  = 256,
  parameter int FRAME_WORDS = 115200,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BASE = '0,
  parameter logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(28'h0400000)
) (
  input  logic                  ui_clk,
  input  logic                  ui_clk_sync_rst,
  input  logic                  init_calib_complete,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  input  logic [PIX_WIDTH-1:0]  pix_data,
  output logic                  pix_ready,
  output logic                  wr_burst_req,
  output logic [9:0]            wr_burst_len,
  output logic [ADDR_WIDTH-1:0] wr_burst_addr,
  input  logic                  wr_burst_data_req,
  output logic [DATA_WIDTH-1:0] wr_burst_data,
  input  logic                  wr_burst_finish,
  output logic                  frame_done,
  output logic                  wr_bank,
  output logic                  overflow,
  output logic                  sync_err
);

  localparam int PPW   = DATA_WIDTH / PIX_WIDTH;
  localparam int PC_W  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int WD_W  = $clog2(FRAME_WORDS + 1);

`ifdef FRAME_WR_PINGPONG_EN
  localparam logic PP_EN = 1'b1;
`else
  localparam logic PP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {WAIT_CAL, IDLE, BURST, UPDATE} state_t;

  // ---------------- packer ----------------
  logic [DATA_WIDTH-1:0] pack_q, pack_d, pack_base, push_word;
  logic [PC_W-1:0]       pcnt_q, pcnt_d, slot;
  logic                  ovf_q, ovf_d, serr_q, serr_d, ready_q, ready_d;
  logic                  accept, push, pop;

  assign accept = pix_valid && ready_q;

  always_comb begin
    pack_d    = pack_q;
    pcnt_d    = pcnt_q;
    ovf_d     = ovf_q;
    serr_d    = serr_q;
    push      = 1'b0;
    pack_base = pack_q;
    slot      = pcnt_q;
    push_word = pack_q;
    if (pix_valid && !ready_q) ovf_d = 1'b1;
    if (accept) begin
      // SOF restarts the word; any partial word is thrown away
      if (pix_sof) begin
        pack_base = '0;
        slot      = '0;
        if (pcnt_q != '0) serr_d = 1'b1;
      end
      for (int k = 0; k < PPW; k++)
        if (slot == PC_W'(k)) pack_base[k*PIX_WIDTH +: PIX_WIDTH] = pix_data;
      if (slot == PC_W'(PPW - 1)) begin
        push      = 1'b1;
        push_word = pack_base;
        pack_d    = '0;
        pcnt_d    = '0;
      end else begin
        pack_d = pack_base;
        pcnt_d = slot + 1'b1;
      end
    end
  end

  // ---------------- word FIFO ----------------
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  assign pop = wr_burst_data_req && (cnt_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    ready_d = (cnt_d < CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge ui_clk)
    if (push) fifo_mem[wr_ptr_q] <= push_word;

  assign wr_burst_data = (cnt_q != '0) ? fifo_mem[rd_ptr_q] : '0;
  assign pix_ready     = ready_q;

  // ---------------- burst sequencer ----------------
  state_t                state_q, state_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d, addr_q, addr_d;
  logic [9:0]            len_q, len_d, len_c;
  logic                  bank_q, bank_d, fdone_c;
  logic [31:0]           remain, wd_sum;

  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    cur_addr_d = cur_addr_q;
    len_d      = len_q;
    addr_d     = addr_q;
    bank_d     = bank_q;
    fdone_c    = 1'b0;
    remain     = 32'(FRAME_WORDS) - 32'(wd_q);
    len_c      = (remain < 32'(BURST_LEN)) ? remain[9:0] : 10'(BURST_LEN);
    wd_sum     = 32'(wd_q) + 32'(len_q);
    case (state_q)
      WAIT_CAL: if (init_calib_complete) state_d = IDLE;
      IDLE: begin
        if (!init_calib_complete) state_d = WAIT_CAL;
        else if (32'(cnt_q) >= 32'(len_c)) begin
          len_d   = len_c;
          addr_d  = cur_addr_q;
          state_d = BURST;
        end
      end
      BURST: if (wr_burst_finish) state_d = UPDATE;
      UPDATE: begin
        state_d = IDLE;
        // one column address per pixel, so a word advances the address by PPW
        if (wd_sum == 32'(FRAME_WORDS)) begin
          fdone_c    = 1'b1;
          wd_d       = '0;
          bank_d     = PP_EN & ~bank_q;
          cur_addr_d = bank_d ? BANK1_BASE : FRAME_BASE;
        end else begin
          wd_d       = WD_W'(wd_sum);
          cur_addr_d = cur_addr_q + ADDR_WIDTH'(32'(len_q) * 32'(PPW));
        end
      end
      default: state_d = WAIT_CAL;
    endcase
  end

  assign wr_burst_req  = (state_q == BURST);
  assign wr_burst_len  = len_q;
  assign wr_burst_addr = addr_q;
  assign frame_done    = fdone_c;
  assign wr_bank       = bank_q;
  assign overflow      = ovf_q;
  assign sync_err      = serr_q;

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      pack_q     <= '0;
      pcnt_q     <= '0;
      ovf_q      <= 1'b0;
      serr_q     <= 1'b0;
      ready_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      state_q    <= WAIT_CAL;
      wd_q       <= '0;
      cur_addr_q <= FRAME_BASE;
      len_q      <= '0;
      addr_q     <= FRAME_BASE;
      bank_q     <= 1'b0;
    end else begin
      pack_q     <= pack_d;
      pcnt_q     <= pcnt_d;
      ovf_q      <= ovf_d;
      serr_q     <= serr_d;
      ready_q    <= ready_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      wd_q       <= wd_d;
      cur_addr_q <= cur_addr_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      bank_q     <= bank_d;
    end
  end

endmodule

// File: doc/frame_wr_ctrl.md
# frame_wr_ctrl

Write-side feeder for the DDR3 burst engine: packs an incoming pixel stream in the `ui_clk` domain into `DATA_WIDTH`-bit words, buffers them in an internal show-ahead FIFO, and issues fixed-length write bursts to `ddr_burst` through its `wr_burst_*` port. Frame addresses advance linearly from a base and wrap at frame end. It sits directly upstream of `ddr_burst`, in place of the `burst_test` write side.

## Interface
- `ADDR_WIDTH`, 28: DDR app address width.
- `DATA_WIDTH`, 128: burst data width.
- `PIX_WIDTH`, 16: pixel width. `DATA_WIDTH/PIX_WIDTH` (PPW, 8 by default) must be an integer.
- `BURST_LEN`, 64: words per burst. Range 1..1023.
- `FIFO_DEPTH`, 256: word FIFO depth. Power of two, ≥ `BURST_LEN`.
- `FRAME_WORDS`, 115200: words per frame.
- `FRAME_BASE`, 0: frame start address (bank 0).
- `BANK1_BASE`, 28'h0400000: bank 1 start address. Used only with ping-pong.
- `ui_clk` in 1: sole clock.
- `ui_clk_sync_rst` in 1: asynchronous, active-high reset.
- `init_calib_complete` in 1: no burst is requested while this is low.
- `pix_valid` in 1: pixel strobe.
- `pix_sof` in 1: first pixel of frame. Qualified by `pix_valid`.
- `pix_data` in PIX_WIDTH: pixel.
- `pix_ready` out 1: a full FIFO word slot is free.
- `wr_burst_req` out 1: burst request. Held until finish.
- `wr_burst_len` out 10: words in the current burst.
- `wr_burst_addr` out ADDR_WIDTH: burst start address.
- `wr_burst_data_req` in 1: `ddr_burst` consumes `wr_burst_data` this cycle.
- `wr_burst_data` out DATA_WIDTH: FIFO head (show-ahead).
- `wr_burst_finish` in 1: burst complete pulse.
- `frame_done` out 1: one-cycle pulse when the last word of a frame has been written.
- `wr_bank` out 1: bank being written.
- `overflow` out 1: sticky flag. A pixel was dropped.
- `sync_err` out 1: sticky flag. A partial word was discarded at SOF.

## Operation
- **Packer**
  - A pixel is accepted iff `pix_valid && pix_ready`.
  - Pixel k of a word lands in bits `[k*PIX_WIDTH +: PIX_WIDTH]`, LSB first.
  - On the PPW-th accepted pixel, the word is pushed into the FIFO.
  - `pix_valid && !pix_ready` drops the pixel and sets `overflow`.
- **SOF handling**
  - An accepted pixel with `pix_sof` becomes pixel 0 of a new word.
  - If the packer held 1..PPW-1 pixels, they are discarded and `sync_err` is set.
  - SOF does not move the DDR address; frame alignment comes from `FRAME_WORDS`.
- **FIFO**
  - `pix_ready = (fifo_count < FIFO_DEPTH)`.
  - A pop occurs on `wr_burst_data_req`. `ddr_burst` never requests more than `wr_burst_len` words.
  - A pop on an empty FIFO cannot occur, because a burst starts only when enough data is present.
- **FSM**
  - `WAIT_CAL`: stay until `init_calib_complete` = 1, then go to `IDLE`.
  - `IDLE`:
    - Compute `len = min(BURST_LEN, FRAME_WORDS - words_done)`.
    - If `fifo_count >= len`, latch `wr_burst_len = len` and `wr_burst_addr = cur_addr`, then go to `BURST`.
  - `BURST`: `wr_burst_req` = 1. On `wr_burst_finish`, go to `UPDATE`.
  - `UPDATE`: `words_done += len` and `cur_addr += len*PPW`.
    - The step is `len*PPW` because one 16-bit DDR3 column address covers one pixel's width; an address step of PPW equals one word.
    - If `words_done == FRAME_WORDS`: pulse `frame_done`, set `words_done = 0`, set `cur_addr` to the active bank base, then go to `IDLE`.
- **Calibration loss**: if `init_calib_complete` falls while in `IDLE`, go to `WAIT_CAL`. A `BURST` in progress always completes.
- **Reset**:
  - FSM goes to `WAIT_CAL`. FIFO and packer are emptied. `cur_addr = FRAME_BASE`, `words_done = 0`.
  - Outputs: `wr_burst_req`, `frame_done`, `overflow`, `sync_err`, `wr_bank` = 0; `wr_burst_len` = 0; `wr_burst_addr = FRAME_BASE`; `wr_burst_data` = 0; `pix_ready` = 0 during reset and 1 on the first cycle after reset.
  - Reset mid-burst abandons the burst with no completion.

## Timing
- The PPW-th pixel accepted at cycle t is in the FIFO, and counted, at t+1.
- `IDLE` with the condition true at t → `wr_burst_req` = 1 at t+1.
  - `len`/`addr` are stable from t+1 until `wr_burst_req` falls.
- `wr_burst_finish` at t → `wr_burst_req` = 0 at t+1 (`UPDATE`). The earliest next `wr_burst_req` is t+3.
- `wr_burst_data` is valid whenever the FIFO is non-empty. The next word appears the cycle after a pop.
- A simultaneous push and pop leaves `fifo_count` unchanged.
- FIFO pointers wrap modulo `FIFO_DEPTH`.
- `frame_done` is asserted during the `UPDATE` cycle.

## Configuration
- `FRAME_WR_PINGPONG_EN` defined:
  - At each frame wrap, `wr_bank` toggles.
  - The next frame base is `BANK1_BASE` when `wr_bank` = 1, else `FRAME_BASE`.
  - `wr_bank` is updated in the same cycle as the `frame_done` pulse.
- Not defined: `wr_bank` is tied 0 and every frame restarts at `FRAME_BASE`.

## Test plan
- Reset, calibration held low, 64 words of pixels pushed → no `wr_burst_req`. Raise calibration → request with len=64, addr=0.
- Pixels 0..7 with values 1..8 → word `0x0008_0007_..._0001` is popped on the first `wr_burst_data_req`.
- With `FRAME_WORDS`=100 and `BURST_LEN`=64, stream 100 words:
  - Bursts (len 64, addr 0) then (len 36, addr 512).
  - `frame_done` pulses once.
  - The next burst is at addr 0, or at `BANK1_BASE` with `wr_bank`=1 when `FRAME_WR_PINGPONG_EN` is defined.
- Hold off `wr_burst_finish` until the FIFO fills → `pix_ready`=0. Further `pix_valid` sets `overflow`, and the FIFO contents are unchanged.
- 3 pixels, then a pixel with `pix_sof` → `sync_err`=1, and the next pushed word starts with the SOF pixel in bits [15:0].
- Assert reset mid-burst → `wr_burst_req`=0 and `wr_burst_addr`=`FRAME_BASE` immediately. The FIFO is empty after release.
